parallel_to_serial: RTL and testbench
=====================================

# parallel_to_serial

Converts a `width`-bit parallel word into a stream of single-bit transfers, LSB first, one bit per accepted serial handshake. It is the transmit side of the serial link whose receiver collects `width` valid bits into a word. Upstream logic hands words in through a valid/ready handshake. Downstream logic can stall the bit stream with `serial_ready`.

## Interface
Parameters:
- `width`, default 8: bits per word; legal range is 2 or more.

Ports:
- `clk`  in  1: clock; all state changes on its rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `parallel_valid`  in  1: upstream word is present.
- `parallel_data`  in  `width`: upstream word.
- `parallel_ready`  out  1: block accepts the word in this cycle.
- `serial_valid`  out  1: `serial_data` holds a valid bit.
- `serial_data`  out  1: current bit.
- `serial_ready`  in  1: downstream takes the current bit in this cycle.

## Operation
- States:
  - IDLE: no word loaded.
  - SHIFT: a word is being sent.
- Counter `bit_cnt` is $clog2(width) bits wide and counts bits already sent of the current word.
- Word accept: a word is accepted when `parallel_valid && parallel_ready` is high at a clock edge.
  - On accept: shift register gets `parallel_data`, `bit_cnt` goes to 0, state goes to SHIFT.
- SHIFT outputs:
  - `serial_valid` = 1.
  - `serial_data` = shift register bit 0.
- Bit transfer: a bit transfers when `serial_valid && serial_ready` is high at a clock edge.
  - On transfer: shift register shifts right by one and fills with 0; `bit_cnt` increments.
- Last bit: transfer with `bit_cnt == width-1`.
  - If a new word is accepted in the same cycle, it loads with `bit_cnt` = 0 and state stays SHIFT. No bubble.
  - Otherwise state goes to IDLE.
- `serial_ready` low: all state holds; `serial_valid` and `serial_data` stay stable until the transfer.
- Outputs in IDLE: `serial_valid` = 0 and `serial_data` = 0.
- Base build: `parallel_ready` = (state == IDLE) || (`bit_cnt == width-1` && `serial_ready`). It depends combinationally on `serial_ready`.
- `parallel_valid` while `parallel_ready` is 0: no effect. Upstream holds the word.

## Timing
- While `rst` is high:
  - state IDLE, `bit_cnt` 0, shift register 0.
  - `serial_valid` 0, `serial_data` 0, `parallel_ready` 1.
  - Inputs are ignored.
- Reset mid-word: the current word is dropped immediately; no partial bits after deassertion.
- Latency: word accepted at edge N → bit 0 is valid in the cycle after edge N. Bit k appears after k further transfers.
- Throughput: with `serial_ready` held at 1 and a word always offered, `serial_valid` stays 1 continuously. The block sends one word every `width` cycles.
- A word fully leaves after exactly `width` transfers. The receiver asserts its word valid on the last of them.

## Configuration
- `PARALLEL_TO_SERIAL_BUF_EN` defined: adds a one-entry input holding register.
  - `parallel_ready` = !buffer_full. It comes from a register, with no combinational path from `serial_ready`.
  - Accept in IDLE loads the shifter directly; accept in SHIFT fills the buffer.
  - On the last-bit transfer with the buffer full: the shifter loads from the buffer and the buffer empties, with no bubble.
  - Reset empties the buffer.
- Macro undefined: base behaviour above; no buffer.
- Serial output timing is identical in both builds.

## Structure
- Package `serial_link_pkg`, shared with the receiver:
  - state enum type (IDLE, SHIFT);
  - function returning the counter width for a given `width`;
  - bit order constant, LSB first.
- Sub-module `p2s_shift_reg`: load, shift and hold control; outputs bit 0.
- The top level holds the FSM, counter, handshake logic and optional buffer.

## Test plan
- Reset, then 8'hA5 offered with `serial_ready`=1 → bits 1,0,1,0,0,1,0,1 on consecutive cycles; `serial_valid` drops afterwards; `parallel_ready` is 1 in IDLE.
- Back-to-back 8'h01, 8'h80 with `serial_ready`=1 → 16 consecutive valid bits, 1 followed by 14 zeros then 1; no gap.
- `serial_ready` toggled 1,0,0,1,… during 8'h3C → each bit held stable while stalled; the bit sequence equals an unstalled run.
- `rst` pulsed after bit 3 of 8'hFF → `serial_valid` goes 0 immediately; the next word 8'h00 starts cleanly at bit 0.
- Loopback into the receiver, `width`=5, random words and random stalls → every received word equals the sent word, in order.
- `PARALLEL_TO_SERIAL_BUF_EN` build: 3 words offered back-to-back → `parallel_ready` drops only when the buffer is full, and the output stream is identical to the base build.

Source files
------------

// File: rtl/serial_link_pkg.sv
// -----------------------------------------------------------------------------
// serial_link_pkg
// Definitions shared by the transmit (parallel_to_serial) and receive sides of
// the single-bit serial link.
//   link_state_t : transmitter state (IDLE, SHIFT)
//   cnt_width()  : bit-counter width for a given word width
//   LSB_FIRST    : bit order on the wire
// -----------------------------------------------------------------------------
package serial_link_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } link_state_t;

    localparam bit LSB_FIRST = 1'b1;

    // Width of a counter that holds 0 .. width-1. Never below one bit.
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/p2s_shift_reg.sv
// -----------------------------------------------------------------------------
// p2s_shift_reg
// Word shifter for the serial transmitter. Load has priority over shift; with
// neither asserted the contents hold. Shifting moves toward the outgoing end
// and fills with zeros, so the register is empty after a full word has left.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset (clears register)
//   i_load        : load i_load_data this cycle
//   i_load_data   : word to load
//   i_shift       : advance by one bit
//   o_bit         : bit currently presented on the link (bit 0 when LSB first)
// -----------------------------------------------------------------------------
module p2s_shift_reg
    import serial_link_pkg::*;
#(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [width-1:0] i_load_data,
    input  logic             i_shift,
    output logic             o_bit
);

    logic [width-1:0] r_shift;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift <= '0;
        end else if (i_load) begin
            r_shift <= i_load_data;
        end else if (i_shift) begin
            if (LSB_FIRST) begin
                r_shift <= {1'b0, r_shift[width-1:1]};
            end else begin
                r_shift <= {r_shift[width-2:0], 1'b0};
            end
        end
    end

    assign o_bit = LSB_FIRST ? r_shift[0] : r_shift[width-1];

endmodule

// File: rtl/parallel_to_serial.sv
// -----------------------------------------------------------------------------
// parallel_to_serial
// Transmit side of the serial link: takes width-bit words over a valid/ready
// handshake and sends them one bit per accepted serial handshake, LSB first.
// A new word can be taken on the same edge as the last bit of the previous one,
// so a continuously offered stream has no idle cycles.
//
// Build option:
//   PARALLEL_TO_SERIAL_BUF_EN : adds a one-entry input holding register;
//                               parallel_ready becomes !buffer_full (registered,
//                               no path from serial_ready). Serial output timing
//                               is unchanged.
//
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   i_parallel_valid  : upstream word present
//   i_parallel_data   : upstream word
//   o_parallel_ready  : word accepted this cycle when valid
//   o_serial_valid    : o_serial_data holds a valid bit
//   o_serial_data     : current bit (0 when idle)
//   i_serial_ready    : downstream takes the current bit this cycle
//
// State | meaning
// IDLE  | no word loaded, serial_valid low
// SHIFT | a word is being sent, bit_cnt = bits of it already sent
// -----------------------------------------------------------------------------
module parallel_to_serial
    import serial_link_pkg::*;
#(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_parallel_valid,
    input  logic [width-1:0] i_parallel_data,
    output logic             o_parallel_ready,
    output logic             o_serial_valid,
    output logic             o_serial_data,
    input  logic             i_serial_ready
);

    localparam int            CW       = cnt_width(width);
    localparam logic [CW-1:0] LAST_CNT = CW'(width - 1);

    link_state_t      r_state;
    logic [CW-1:0]    r_bit_cnt;

    logic             w_xfer;
    logic             w_last_xfer;
    logic             w_accept;
    logic             w_load;
    logic [width-1:0] w_load_data;
    logic             w_bit;

    assign w_xfer      = (r_state == SHIFT) && i_serial_ready;
    assign w_last_xfer = w_xfer && (r_bit_cnt == LAST_CNT);

`ifdef PARALLEL_TO_SERIAL_BUF_EN
    logic             r_buf_full;
    logic [width-1:0] r_buf_data;

    assign o_parallel_ready = !r_buf_full;
    assign w_accept         = i_parallel_valid && !r_buf_full;

    // The shifter takes a new word when idle, or on the last bit: a buffered
    // word goes first, otherwise a word accepted on that very edge goes
    // straight in so there is no bubble.
    assign w_load      = ((r_state == IDLE) && w_accept) ||
                         (w_last_xfer && (r_buf_full || w_accept));
    assign w_load_data = r_buf_full ? r_buf_data : i_parallel_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_buf_full <= 1'b0;
            r_buf_data <= '0;
        end else if (w_accept && !w_load) begin
            r_buf_full <= 1'b1;
            r_buf_data <= i_parallel_data;
        end else if (w_last_xfer && r_buf_full) begin
            r_buf_full <= 1'b0;
        end
    end
`else
    // Ready on the last bit only when that bit actually leaves this cycle,
    // which makes this a combinational function of i_serial_ready.
    assign o_parallel_ready = (r_state == IDLE) ||
                              ((r_bit_cnt == LAST_CNT) && i_serial_ready);
    assign w_accept         = i_parallel_valid && o_parallel_ready;
    assign w_load           = w_accept;
    assign w_load_data      = i_parallel_data;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_bit_cnt <= '0;
        end else if (r_state == IDLE) begin
            if (w_load) begin
                r_state   <= SHIFT;
                r_bit_cnt <= '0;
            end
        end else if (w_xfer) begin
            if (w_last_xfer) begin
                r_bit_cnt <= '0;
                r_state   <= w_load ? SHIFT : IDLE;
            end else begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
        end
    end

    p2s_shift_reg #(
        .width(width)
    ) u_shift_reg (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_load_data(w_load_data),
        .i_shift    (w_xfer),
        .o_bit      (w_bit)
    );

    assign o_serial_valid = (r_state == SHIFT);
    assign o_serial_data  = w_bit && (r_state == SHIFT);

endmodule

// File: tb/tb_parallel_to_serial.sv
// -----------------------------------------------------------------------------
// tb_parallel_to_serial
// Bench for parallel_to_serial: a width-8 instance checked cycle by cycle
// against a queue-of-bits reference model, and a width-5 instance looped back
// into a behavioural receiver.
// -----------------------------------------------------------------------------
module tb_parallel_to_serial;

`ifdef PARALLEL_TO_SERIAL_BUF_EN
    localparam bit BUF = 1'b1;
`else
    localparam bit BUF = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       pv, sr, pr, sv, sd;
    logic [7:0] pd;
    logic       pv5, sr5, pr5, sv5, sd5;
    logic [4:0] pd5;

    parallel_to_serial #(.width(8)) dut8 (
        .clk(clk), .rst(rst),
        .i_parallel_valid(pv), .i_parallel_data(pd), .o_parallel_ready(pr),
        .o_serial_valid(sv), .o_serial_data(sd), .i_serial_ready(sr)
    );

    parallel_to_serial #(.width(5)) dut5 (
        .clk(clk), .rst(rst),
        .i_parallel_valid(pv5), .i_parallel_data(pd5), .o_parallel_ready(pr5),
        .o_serial_valid(sv5), .o_serial_data(sd5), .i_serial_ready(sr5)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: bits still to leave for the word in flight, plus the
    // optional one-word holding register.
    bit         m_cur[$];
    bit         m_buf_v;
    logic [7:0] m_buf;
    bit         stream[$];
    int         v_first, v_last;

    task automatic load_word(input logic [7:0] w);
        for (int i = 0; i < 8; i++) m_cur.push_back(w[i]);
    endtask

    // One clock of the width-8 DUT: drive, compare at negedge, advance model.
    task automatic cycle8(input logic ipv, input logic [7:0] ipd, input logic isr,
                          output bit acc, output logic a_sv, output logic a_sd,
                          output logic a_pr);
        bit e_sv, e_sd, e_pr, xfer;
        pv = ipv; pd = ipd; sr = isr;
        e_sv = (m_cur.size() > 0);
        e_sd = e_sv ? m_cur[0] : 1'b0;
        e_pr = BUF ? !m_buf_v : ((m_cur.size() == 0) || (m_cur.size() == 1 && isr));
        @(negedge clk);
        a_sv = sv; a_sd = sd; a_pr = pr;
        check("serial_valid", a_sv, e_sv);
        check("serial_data", a_sd, e_sd);
        check("parallel_ready", a_pr, e_pr);
        xfer = e_sv && isr;
        acc  = ipv && e_pr;
        if (a_sv && isr) stream.push_back(a_sd);
        @(posedge clk); #1;
        if (xfer) void'(m_cur.pop_front());
        if (BUF && m_cur.size() == 0 && m_buf_v) begin
            load_word(m_buf);
            m_buf_v = 1'b0;
        end
        if (acc) begin
            if (m_cur.size() == 0) load_word(ipd);
            else begin
                m_buf   = ipd;
                m_buf_v = 1'b1;
            end
        end
    endtask

    // Offer words in order (held until accepted) and compare the bit stream.
    // mode 0: serial_ready always 1; 1: ready pattern 1,0,0,1; 2: random.
    task automatic send_words(input string name, input logic [7:0] w[$],
                              input int mode, input int max_cycles);
        int idx = 0;
        int n = 0;
        bit acc, offering, srv, prev_stall;
        logic a_sv, a_sd, a_pr, prev_sd;
        logic [7:0] got;
        offering = 1'b1;
        prev_stall = 1'b0;
        prev_sd = 1'b0;
        stream.delete();
        v_first = -1;
        v_last = -1;
        while ((idx < w.size() || m_cur.size() > 0 || m_buf_v) && n < max_cycles) begin
            case (mode)
                0:       srv = 1'b1;
                1:       srv = (n % 4 == 0) || (n % 4 == 3);
                default: srv = ($urandom_range(0, 3) != 0);
            endcase
            if (mode == 2 && !offering) offering = ($urandom_range(0, 2) != 0);
            cycle8(offering && idx < w.size(), (idx < w.size()) ? w[idx] : 8'h00, srv,
                   acc, a_sv, a_sd, a_pr);
            if (prev_stall) begin
                check({name, "_stall_valid"}, a_sv, 1'b1);
                check({name, "_stall_data"}, a_sd, prev_sd);
            end
            prev_stall = a_sv && !srv;
            prev_sd = a_sd;
            if (a_sv) begin
                if (v_first < 0) v_first = n;
                v_last = n;
            end
            if (acc) begin
                idx++;
                if (mode == 2) offering = 1'b0;
            end
            n++;
        end
        check({name, "_done"}, n < max_cycles, 1'b1);
        check({name, "_nbits"}, stream.size(), 8 * w.size());
        for (int i = 0; i < w.size(); i++) begin
            got = 'x;
            if (stream.size() >= 8 * (i + 1))
                for (int b = 0; b < 8; b++) got[b] = stream[8 * i + b];
            check({name, "_word"}, got, w[i]);
        end
    endtask

    typedef struct packed {
        logic       pv;
        logic [7:0] pd;
        logic       sr;
        logic       sv;
        logic       sd;
        logic       pr;
    } vec_t;

    function automatic vec_t mk(input logic ipv, input logic [7:0] ipd, input logic isr,
                                input logic esv, input logic esd, input logic epr);
        vec_t v;
        v.pv = ipv; v.pd = ipd; v.sr = isr; v.sv = esv; v.sd = esd; v.pr = epr;
        return v;
    endfunction

    task automatic loop5(input int nwords, input int max_cycles);
        logic [4:0] w5[$];
        bit rx[$];
        logic [4:0] got;
        int idx = 0;
        int rcv = 0;
        int n = 0;
        bit offering = 1'b0;
        bit prev_stall = 1'b0;
        logic prev_sd = 1'b0;
        for (int i = 0; i < nwords; i++) w5.push_back(5'($urandom_range(0, 31)));
        while (rcv < nwords && n < max_cycles) begin
            if (!offering) offering = ($urandom_range(0, 2) != 0);
            pv5 = offering && idx < nwords;
            pd5 = (idx < nwords) ? w5[idx] : 5'd0;
            sr5 = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            if (prev_stall) begin
                check("loop5_stall_valid", sv5, 1'b1);
                check("loop5_stall_data", sd5, prev_sd);
            end
            prev_stall = sv5 && !sr5;
            prev_sd = sd5;
            if (pv5 && pr5) begin
                idx++;
                offering = 1'b0;
            end
            if (sv5 && sr5) begin
                rx.push_back(sd5);
                if (rx.size() == 5) begin
                    for (int b = 0; b < 5; b++) got[b] = rx[b];
                    rx.delete();
                    check("loop5_word", got, w5[rcv]);
                    rcv++;
                end
            end
            @(posedge clk); #1;
            n++;
        end
        pv5 = 1'b0;
        sr5 = 1'b0;
        check("loop5_count", rcv, nwords);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[10];
        logic [7:0] wq[$];
        bit acc;
        logic a_sv, a_sd, a_pr;

        rst = 1'b1;
        pv = 0; pd = 0; sr = 0;
        pv5 = 0; pd5 = 0; sr5 = 0;
        m_buf_v = 1'b0;
        m_buf = '0;

        // Inputs driven during reset must be ignored.
        repeat (2) @(posedge clk);
        #1;
        pv = 1'b1; pd = 8'hFF; sr = 1'b1;
        pv5 = 1'b1; pd5 = 5'h1F; sr5 = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("rst_serial_valid", sv, 1'b0);
            check("rst_serial_data", sd, 1'b0);
            check("rst_parallel_ready", pr, 1'b1);
            check("rst_serial_valid5", sv5, 1'b0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        pv = 0; pd = 0; sr = 0;
        pv5 = 0; pd5 = 0; sr5 = 0;

        // 8'hA5 with serial_ready=1: bits LSB first, then back to idle.
        tbl[0] = mk(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b1);
        tbl[1] = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, BUF);
        tbl[2] = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, BUF);
        tbl[3] = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, BUF);
        tbl[4] = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, BUF);
        tbl[5] = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, BUF);
        tbl[6] = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, BUF);
        tbl[7] = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, BUF);
        tbl[8] = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1);
        tbl[9] = mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            cycle8(tbl[i].pv, tbl[i].pd, tbl[i].sr, acc, a_sv, a_sd, a_pr);
            check("tbl_serial_valid", a_sv, tbl[i].sv);
            check("tbl_serial_data", a_sd, tbl[i].sd);
            check("tbl_parallel_ready", a_pr, tbl[i].pr);
        end

        // Back-to-back words: 16 consecutive valid bits, no gap.
        wq = '{8'h01, 8'h80};
        send_words("b2b", wq, 0, 40);
        check("b2b_span", v_last - v_first + 1, 16);

        // Stalled run: bits held while stalled, same sequence as unstalled.
        wq = '{8'h3C};
        send_words("stall", wq, 1, 40);

        // Reset after bit 3 of 8'hFF drops the word at once.
        stream.delete();
        begin
            int n = 0;
            cycle8(1'b1, 8'hFF, 1'b1, acc, a_sv, a_sd, a_pr);
            while (stream.size() < 4 && n < 20) begin
                cycle8(1'b0, 8'h00, 1'b1, acc, a_sv, a_sd, a_pr);
                n++;
            end
            check("rstmid_bits_before", stream.size(), 4);
        end
        rst = 1'b1;
        #1;
        check("rstmid_serial_valid", sv, 1'b0);
        check("rstmid_serial_data", sd, 1'b0);
        check("rstmid_parallel_ready", pr, 1'b1);
        m_cur.delete();
        m_buf_v = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        wq = '{8'h00};
        send_words("after_rst", wq, 0, 20);
        check("after_rst_span", v_last - v_first + 1, 8);

        // Three words offered back-to-back.
        wq = '{8'h5A, 8'hC3, 8'h0F};
        send_words("three", wq, 0, 60);
        check("three_span", v_last - v_first + 1, 24);

        // Random words, random stalls and upstream gaps.
        wq.delete();
        for (int i = 0; i < 40; i++) wq.push_back(8'($urandom_range(0, 255)));
        send_words("rand8", wq, 2, 2000);

        // Width-5 loopback into a behavioural receiver.
        loop5(60, 3000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
